// File: rtl/wire_lab_pkg.sv
// Shared types and constants for the wire lab stimulus sequencer.
// Holds the FSM encoding, the step-to-{W,X} table and the result helpers.
package wire_lab_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int         NSTEPS  = 5;
   localparam logic [2:0] NO_FAIL = 3'd7;

   // Bits [2s+1:2s] hold {W,X} for step s: 00, 10, 11, 01, 00.
   localparam logic [9:0] WX_LUT = 10'b00_01_11_10_00;

   function automatic logic [1:0] wx_of_step(input logic [2:0] s);
      logic [9:0] lut;
      logic [1:0] wx;
      lut = WX_LUT;
      wx  = 2'b00;
      for (int i = 0; i < NSTEPS; i++) begin
         if (s == 3'(i)) wx = lut[2*i +: 2];
      end
      return wx;
   endfunction

   function automatic logic [2:0] first_fail(input logic [9:0] cap,
                                             input logic [9:0] exp);
      logic [2:0] r;
      r = NO_FAIL;
      // Scan downward so the lowest mismatching step wins.
      for (int i = NSTEPS - 1; i >= 0; i--) begin
         if (cap[2*i +: 2] != exp[2*i +: 2]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/wire_seq_dwell.sv
// Dwell counter: counts enabled cycles and flags the last cycle of a step.
// Wraps to zero on its terminal count; i_clr restarts it for a new run.
module wire_seq_dwell #(
   parameter int DWELL = 20,
   parameter int CW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_en,
   output logic          o_tc,
   output logic [CW-1:0] o_count
);

   generate
      if (DWELL < 1 || (DWELL - 1) >= (1 << CW)) begin : g_bad_dwell
         $error("wire_seq_dwell: DWELL=%0d does not fit in CW=%0d bits", DWELL, CW);
      end
   endgenerate

   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] r_count;
   logic          w_tc;

   assign w_tc    = i_en && (r_count == LAST);
   assign o_tc    = w_tc;
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_tc ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/wire_seq_ctrl.sv
// Stimulus sequencer for the wire lab datapath: walks W/X through five steps,
// samples Y/Z at the end of each step and compares against an expected vector.
module wire_seq_ctrl
   import wire_lab_pkg::*;
#(
   parameter int DWELL = 20,
   parameter int CW    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y_in,
   input  logic       z_in,
   input  logic [9:0] expected,
   output logic       w_out,
   output logic       x_out,
   output logic       busy,
   output logic       done,
   output logic [2:0] step,
   output logic [9:0] capture,
   output logic       mismatch,
   output logic [2:0] fail_step,
   output state_t     dbg_state
);

   // Handshake: start is a level request accepted only in IDLE; busy is high
   // for the whole run, done pulses once, and the results stay valid from the
   // done pulse until the next accepted start.

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_step;
   logic       r_w;
   logic       r_x;
   logic [9:0] r_capture;
   logic       r_mismatch;
   logic [2:0] r_fail_step;

   logic       w_accept;
   logic       w_run;
   logic       w_tc;
   logic       w_last;
   logic [9:0] w_cap_nxt;
   logic [CW-1:0] w_count;

   assign w_run    = (r_state == RUN);
   assign w_accept = (r_state == IDLE) && start;
   assign w_last   = w_tc && (r_step == 3'(NSTEPS - 1));

   wire_seq_dwell #(
      .DWELL (DWELL),
      .CW    (CW)
   ) u_dwell (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_accept),
      .i_en    (w_run),
      .o_tc    (w_tc),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start)  w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Capture vector with the current step's sample merged in, so the compare
   // on the final step sees all five samples in the same edge.
   always_comb begin
      w_cap_nxt = r_capture;
      for (int i = 0; i < NSTEPS; i++) begin
         if (r_step == 3'(i)) w_cap_nxt[2*i +: 2] = {y_in, z_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_step      <= 3'd0;
         r_w         <= 1'b0;
         r_x         <= 1'b0;
         r_capture   <= 10'd0;
         r_mismatch  <= 1'b0;
         r_fail_step <= NO_FAIL;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_step         <= 3'd0;
                  {r_w, r_x}     <= wx_of_step(3'd0);
                  r_capture      <= 10'd0;
                  r_mismatch     <= 1'b0;
                  r_fail_step    <= NO_FAIL;
               end
            end
            RUN: begin
               if (w_tc) begin
                  r_capture <= w_cap_nxt;
                  if (w_last) begin
                     r_step      <= 3'd0;
                     {r_w, r_x}  <= 2'b00;
                     r_mismatch  <= (w_cap_nxt != expected);
                     r_fail_step <= first_fail(w_cap_nxt, expected);
                  end else begin
                     r_step     <= r_step + 3'd1;
                     {r_w, r_x} <= wx_of_step(r_step + 3'd1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign w_out     = r_w;
   assign x_out     = r_x;
   assign busy      = w_run;
   assign done      = (r_state == DONE);
   assign step      = r_step;
   assign capture   = r_capture;
   assign mismatch  = r_mismatch;
   assign fail_step = r_fail_step;
   assign dbg_state = r_state;

endmodule
